// File: rtl/fifoc2cs.sv
// fifoc2cs: responder end of the cs fs/fd handshake. Drains one command frame from fifoc,
// checks the header (and checksum when FIFOC2CS_CSUM_EN is defined) and latches the command bytes.
module fifoc2cs #(
    parameter logic [7:0]    HEAD0 = 8'h55,
    parameter logic [7:0]    HEAD1 = 8'hAA,
    parameter int unsigned   TW    = 16,
    parameter logic [TW-1:0] TOUT  = 16'd4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic       fd,
    output logic       err,
    input  logic [7:0] fifoc_rxd,
    input  logic       fifoc_empty,
    output logic       fifoc_rden,
    output logic [7:0] cmd_kdev,
    output logic [7:0] cmd_smpr,
    output logic [7:0] cmd_filt,
    output logic [7:0] cmd_mix0,
    output logic [7:0] cmd_mix1,
    output logic [7:0] cmd_reg4,
    output logic [7:0] cmd_reg5,
    output logic [7:0] cmd_reg6,
    output logic [7:0] cmd_reg7,
    output logic [7:0] frm_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

`ifdef FIFOC2CS_CSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    logic [2:0]      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            err_pend_q, err_pend_d;
    logic            err_q, err_d;
    logic [8:0][7:0] shd_q, shd_d;
    logic [8:0][7:0] cmd_q, cmd_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      sidx;
    logic            hdr_bad;
`ifdef FIFOC2CS_CSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    assign sidx    = idx_q - 4'd2;
    assign hdr_bad = ((idx_q == 4'd0) && (fifoc_rxd != HEAD0)) ||
                     ((idx_q == 4'd1) && (fifoc_rxd != HEAD1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        shd_d      = shd_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
`ifdef FIFOC2CS_CSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fs) begin
                    state_d = S_RD;
                    idx_d   = '0;
                    tcnt_d  = '0;
`ifdef FIFOC2CS_CSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_RD: begin
                if (!fifoc_empty) begin
                    state_d = S_CAP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_d == TOUT) begin
                        err_pend_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_CAP: begin
                tcnt_d = '0;
                if (hdr_bad) begin
                    // Header abort leaves the rest of the frame in fifoc.
                    err_pend_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    if ((idx_q >= 4'd2) && (idx_q <= 4'd10)) begin
                        shd_d[sidx] = fifoc_rxd;
`ifdef FIFOC2CS_CSUM_EN
                        sum_d = sum_q + fifoc_rxd;
`endif
                    end
`ifdef FIFOC2CS_CSUM_EN
                    if ((idx_q == 4'd11) && (fifoc_rxd != sum_q)) begin
                        err_pend_d = 1'b1;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_RD;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            S_CHK: begin
                if (err_pend_q) begin
                    err_d = 1'b1;
                end else begin
                    cmd_d = shd_q;
                    cnt_d = cnt_q + 8'd1;
                    err_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!fs) begin
                    state_d    = S_IDLE;
                    err_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tcnt_q     <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            shd_q      <= '0;
            cmd_q      <= '0;
            cnt_q      <= '0;
`ifdef FIFOC2CS_CSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tcnt_q     <= tcnt_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            shd_q      <= shd_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
`ifdef FIFOC2CS_CSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign fd         = (state_q == S_DONE);
    assign fifoc_rden = (state_q == S_RD) && !fifoc_empty;
    assign err        = err_q;
    assign frm_cnt    = cnt_q;
    assign cmd_kdev   = cmd_q[0];
    assign cmd_smpr   = cmd_q[1];
    assign cmd_filt   = cmd_q[2];
    assign cmd_mix0   = cmd_q[3];
    assign cmd_mix1   = cmd_q[4];
    assign cmd_reg4   = cmd_q[5];
    assign cmd_reg5   = cmd_q[6];
    assign cmd_reg6   = cmd_q[7];
    assign cmd_reg7   = cmd_q[8];

endmodule

// File: tb/tb_fifoc2cs.sv
// Self-checking bench for fifoc2cs: FIFO model plus a scoreboard of expected frame outcomes.
module tb_fifoc2cs;

    localparam logic [15:0] TOUT_TB = 16'd16;
`ifdef FIFOC2CS_CSUM_EN
    localparam int unsigned LEN = 12;
`else
    localparam int unsigned LEN = 11;
`endif

    logic       clk;
    logic       rst;
    logic       fs;
    logic       fd;
    logic       err;
    logic [7:0] fifoc_rxd;
    logic       fifoc_empty;
    logic       fifoc_rden;
    logic [7:0] cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
    logic [7:0] cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
    logic [7:0] frm_cnt;

    fifoc2cs #(
        .HEAD0(8'h55),
        .HEAD1(8'hAA),
        .TW   (16),
        .TOUT (TOUT_TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fs         (fs),
        .fd         (fd),
        .err        (err),
        .fifoc_rxd  (fifoc_rxd),
        .fifoc_empty(fifoc_empty),
        .fifoc_rden (fifoc_rden),
        .cmd_kdev   (cmd_kdev),
        .cmd_smpr   (cmd_smpr),
        .cmd_filt   (cmd_filt),
        .cmd_mix0   (cmd_mix0),
        .cmd_mix1   (cmd_mix1),
        .cmd_reg4   (cmd_reg4),
        .cmd_reg5   (cmd_reg5),
        .cmd_reg6   (cmd_reg6),
        .cmd_reg7   (cmd_reg7),
        .frm_cnt    (frm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: main process owns wr_ptr and mem, the read process owns rd_ptr.
    logic [7:0]  mem [64];
    int unsigned wr_ptr;
    int unsigned rd_ptr;
    int unsigned bad_rd;
    logic        toggle;
    logic        gate;

    initial begin
        rd_ptr    = 0;
        bad_rd    = 0;
        fifoc_rxd = 8'h00;
    end

    always @(posedge clk) begin
        if (fifoc_rden) begin
            if (fifoc_empty) bad_rd <= bad_rd + 1;
            fifoc_rxd <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    initial gate = 1'b0;
    always @(negedge clk) gate <= toggle ? ~gate : 1'b0;

    assign fifoc_empty = (wr_ptr == rd_ptr) || gate;

    typedef struct packed {
        logic        err;
        logic [71:0] cmd;
        logic [7:0]  cnt;
        logic [7:0]  nrd;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk;
    int unsigned n_err;
    logic [71:0] mdl_cmd;
    logic [7:0]  mdl_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] dut_cmd();
        return {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
                cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};
    endfunction

    task automatic load_frame(input logic [71:0] c, input logic [7:0] h1,
                              input logic [7:0] csum_adj, input int unsigned nbytes);
        logic [7:0]  fr [12];
        logic [7:0]  sum;
        sum   = 8'h00;
        fr[0] = 8'h55;
        fr[1] = h1;
        for (int i = 0; i < 9; i++) begin
            fr[i+2] = c[71-8*i -: 8];
            sum     = sum + fr[i+2];
        end
        fr[11] = sum + csum_adj;
        for (int i = 0; i < 12; i++) begin
            if (i < nbytes && i < LEN) begin
                mem[wr_ptr % 64] = fr[i];
                wr_ptr++;
            end
        end
    endtask

    task automatic run_frame(input string tag);
        int unsigned rd0;
        exp_t        e;
        logic [71:0] got;
        rd0 = rd_ptr;
        fs  = 1'b1;
        for (int i = 0; i < 300 && !fd; i++) @(negedge clk);
        check({tag, "_fd"}, fd, 1);
        e   = sb.pop_front();
        got = dut_cmd();
        check({tag, "_err"}, err, e.err);
        for (int b = 0; b < 9; b++) check({tag, "_cmd"}, got[71-8*b -: 8], e.cmd[71-8*b -: 8]);
        check({tag, "_cnt"}, frm_cnt, e.cnt);
        check({tag, "_nrd"}, rd_ptr - rd0, e.nrd);
        repeat (3) @(negedge clk);
        check({tag, "_fd_hold"}, fd, 1);
        check({tag, "_no_retrig"}, rd_ptr - rd0, e.nrd);
        fs = 1'b0;
        @(negedge clk);
        check({tag, "_fd_fall"}, fd, 0);
        wr_ptr = rd_ptr;
        @(negedge clk);
    endtask

    task automatic expect_frame(input logic ok, input logic [71:0] c, input int unsigned nrd);
        exp_t e;
        if (ok) begin
            mdl_cmd = c;
            mdl_cnt = mdl_cnt + 8'd1;
        end
        e.err = ~ok;
        e.cmd = mdl_cmd;
        e.cnt = mdl_cnt;
        e.nrd = 8'(nrd);
        sb.push_back(e);
    endtask

    initial begin
        int unsigned rd0;
        logic [71:0] got;
        n_chk   = 0;
        n_err   = 0;
        wr_ptr  = 0;
        toggle  = 1'b0;
        fs      = 1'b0;
        rst     = 1'b0;
        mdl_cmd = '0;
        mdl_cnt = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_fd", fd, 0);
        check("rst_err", err, 0);
        check("rst_rden", fifoc_rden, 0);
        check("rst_cnt", frm_cnt, 0);
        got = dut_cmd();
        check("rst_cmd_hi", got[71:40], 0);
        check("rst_cmd_lo", got[39:8], 0);
        rst = 1'b1;
        @(negedge clk);

        load_frame(72'h010203040506070809, 8'hAA, 8'h00, 12);
        expect_frame(1'b1, 72'h010203040506070809, LEN);
        run_frame("good");

        load_frame(72'hF1F2F3F4F5F6F7F8F9, 8'hAB, 8'h00, 12);
        expect_frame(1'b0, '0, 2);
        run_frame("hdr");

`ifdef FIFOC2CS_CSUM_EN
        load_frame(72'hA1A2A3A4A5A6A7A8A9, 8'hAA, 8'h01, 12);
        expect_frame(1'b0, '0, 12);
        run_frame("csum");
`endif

        load_frame(72'hC1C2C3C4C5C6C7C8C9, 8'hAA, 8'h00, 5);
        expect_frame(1'b0, '0, 5);
        run_frame("stall");

        toggle = 1'b1;
        load_frame(72'h112233445566778899, 8'hAA, 8'h00, 12);
        expect_frame(1'b1, 72'h112233445566778899, LEN);
        run_frame("toggle");
        toggle = 1'b0;

        rd0 = rd_ptr;
        load_frame(72'h5152535455565758FE, 8'hAA, 8'h00, 12);
        fs = 1'b1;
        for (int i = 0; i < 100 && (rd_ptr - rd0) < 6; i++) @(negedge clk);
        check("mid_wait", (rd_ptr - rd0) >= 6, 1);
        rst = 1'b0;
        #1;
        check("mid_fd", fd, 0);
        check("mid_err", err, 0);
        check("mid_rden", fifoc_rden, 0);
        check("mid_cnt", frm_cnt, 0);
        got = dut_cmd();
        check("mid_cmd_hi", got[71:40], 0);
        check("mid_cmd_lo", got[39:8], 0);
        check("mid_cmd_b8", got[7:0], 0);
        mdl_cmd = '0;
        mdl_cnt = 8'd0;
        fs      = 1'b0;
        @(negedge clk);
        wr_ptr = rd_ptr;
        rst    = 1'b1;
        @(negedge clk);
        load_frame(72'h9A9B9C9D9E9F0A0B0C, 8'hAA, 8'h00, 12);
        expect_frame(1'b1, 72'h9A9B9C9D9E9F0A0B0C, LEN);
        run_frame("post_rst");

        check("rden_while_empty", bad_rd, 0);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
